dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the SISC datapath: the memory-side end of the control FSM's data-memory port. It accepts single-word load/store requests over a req/ack handshake, inserts a configurable number of wait states, and performs the access on an internal word array. Read data is registered and held until the next read completes. It replaces the zero-latency memory so the control FSM can be exercised against a multi-cycle memory.

## Interface
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W words.
- DATA_W, 32, data word width.
- WAIT, 2, wait states inserted before the access edge (0..15).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_f  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  store data; sampled with req.
- rdata  out  DATA_W  registered load data.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE:**
  - If req=1 at an edge (capture edge E0), latch we, addr and wdata.
  - If WAIT=0, perform the access at E0 and go to ACK.
  - Otherwise load the wait counter and go to WAIT.
- **WAIT:**
  - The counter decrements on each edge.
  - The access is performed at edge E0+WAIT, and the FSM enters ACK at that edge.
  - req, we, addr and wdata are ignored in this state.
- **Access:**
  - Store: write the latched wdata to mem[latched addr]. rdata is unchanged.
  - Load: rdata takes mem[latched addr].
- **ACK:**
  - ack=1 for exactly this one cycle.
  - The next edge always returns to IDLE; req is not sampled in ACK.
  - A req still high in the following IDLE cycle starts a new request. The requester drops req on seeing ack.
- Back-to-back throughput is one request per WAIT+2 cycles.
- Load after store to the same address returns the stored value, because the accesses are strictly serialized.
- Address is a full ADDR_W index; there is no out-of-range case and no wrap logic.
- **Reset (async, rst_f=0):**
  - state=IDLE, ack=0, busy=0, rdata=0, wait counter=0.
  - Array contents are not reset.
  - A request in WAIT is aborted and its store is not committed.
  - A store whose access edge has already occurred stays committed.

## Timing
- Capture at E0. Access edge at E0+WAIT. ack is high from E0+WAIT to E0+WAIT+1.
- rdata is valid when ack is high and holds until the next load's access edge.
- busy rises at E0 and falls at E0+WAIT+1.
- Example with WAIT=0: ack is high in the cycle immediately after the capture edge.
- There is no combinational path from inputs to outputs.

## Configuration
- Macro: DMEM_POSTED_WR_EN.
- **Defined:**
  - A store is committed at E0 and goes directly to ACK, regardless of WAIT.
  - Store latency is 1 cycle; loads still use WAIT.
- **Undefined:** stores and loads both use the WAIT latency described above.

## Test plan
- **Reset:** hold rst_f=0 mid-cycle with req=1.
  - rdata=0, ack=0 and busy=0 immediately, without waiting for an edge.
  - After release, an idle cycle with req=0 keeps ack=0.
- **Store then load (WAIT=2):**
  - Store 0xDEADBEEF to addr 0x10, capture at E0: ack high only between E2 and E3.
  - Load addr 0x10 issued afterwards: rdata=0xDEADBEEF with ack, held for ≥5 cycles after.
- **Inputs ignored while busy (WAIT=2):** change addr and wdata to 0x11 / 0x12345678 during WAIT.
  - Store lands at 0x10 with the originally captured data.
  - mem[0x11] is unchanged.
- **req held high across ack (WAIT=2):**
  - A second request is captured in the first IDLE cycle after ACK.
  - ack pulses are exactly 4 cycles apart.
- **Reset mid-operation:** assert rst_f=0 one cycle after capturing a store of 0xCAFEF00D to 0x20.
  - A subsequent load of 0x20 returns its prior value, 0x00000000 as preloaded by the bench.
- **DMEM_POSTED_WR_EN defined, WAIT=3:**
  - A store is acked one cycle after capture.
  - A following load of the same address is acked 4 cycles after its capture, with the stored data.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Request/response bus between the SISC control FSM and the data-memory responder.
// The requester uses the master modport; dmem_resp uses the slave modport.
interface dmem_resp_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: req/ack handshake, WAIT wait states, internal word array.
// Optional macro DMEM_POSTED_WR_EN commits stores at the capture edge and acks them without waiting.
module dmem_resp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  dmem_resp_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic       NO_WAIT   = (WAIT == 0);
  // The counter reaching zero marks the access edge, so it starts one below WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
`ifdef DMEM_POSTED_WR_EN
  localparam logic       POSTED_WR = 1'b1;
`else
  localparam logic       POSTED_WR = 1'b0;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ack_r;
  logic              busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              direct_s;
  logic              capture_s;
  logic              access_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic              mem_wr_s;
  logic              mem_rd_s;

  // A request skips WAIT when there are no wait states or when it is a posted store.
  assign direct_s = NO_WAIT | (POSTED_WR & bus.we);

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) begin
          if (direct_s) begin
            state_next_s = ST_ACK;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Control decode; an access in IDLE uses the live bus since capture and access share the edge.
  always_comb begin
    capture_s   = 1'b0;
    access_s    = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        acc_we_s    = bus.we;
        acc_addr_s  = bus.addr;
        acc_wdata_s = bus.wdata;
        if (bus.req) begin
          capture_s = 1'b1;
          if (direct_s) begin
            access_s = 1'b1;
          end else begin
            cnt_load_s = 1'b1;
          end
        end else begin
          capture_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_ACK: begin
        access_s = 1'b0;
      end
      default: begin
        access_s = 1'b0;
      end
    endcase
  end

  // Writes are gated by reset so a request pending under reset never reaches the array.
  assign mem_wr_s = access_s & acc_we_s & rst_f;
  assign mem_rd_s = access_s & ~acc_we_s;

  // Request capture registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (capture_s) begin
      we_r    <= bus.we;
      addr_r  <= bus.addr;
      wdata_r <= bus.wdata;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Wait-state counter.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_r <= 4'd0;
    end else if (cnt_load_s) begin
      cnt_r <= WAIT_LOAD;
    end else if (cnt_dec_s) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[acc_addr_s] <= acc_wdata_s;
    end
  end

  // Load data register, held until the next load's access edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rdata_r <= '0;
    end else if (mem_rd_s) begin
      rdata_r <= mem_r[acc_addr_s];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ack_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ack_r  <= (state_next_s == ST_ACK);
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ack   = ack_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (WAIT=2 and WAIT=3) checked against a per-instance memory model.
// Latency expectations follow DMEM_POSTED_WR_EN when the bench is compiled with it.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  dmem_resp_if #(.ADDR_W(8), .DATA_W(32)) if2 ();
  dmem_resp_if #(.ADDR_W(8), .DATA_W(32)) if3 ();

  dmem_resp #(.ADDR_W(8), .DATA_W(32), .WAIT(2)) dut2 (.clk(clk), .rst_f(rst_f), .bus(if2));
  dmem_resp #(.ADDR_W(8), .DATA_W(32), .WAIT(3)) dut3 (.clk(clk), .rst_f(rst_f), .bus(if3));

`ifdef DMEM_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference memory, one image per instance (index 0 -> WAIT=2, 1 -> WAIT=3).
  logic [31:0] ref_mem   [2][256];
  bit          ref_known [2][256];

  function automatic int exp_lat(input int which, input logic w);
    if (w && POSTED) return 0;
    return (which == 3) ? 3 : 2;
  endfunction

  task automatic model_store(input int which, input logic [7:0] a, input logic [31:0] d);
    ref_mem[which - 2][a]   = d;
    ref_known[which - 2][a] = 1'b1;
  endtask

  task automatic set_bus(input int which, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
    if (which == 3) begin
      if3.req = r; if3.we = w; if3.addr = a; if3.wdata = d;
    end else begin
      if2.req = r; if2.we = w; if2.addr = a; if2.wdata = d;
    end
  endtask

  function automatic logic get_ack(input int which);
    return (which == 3) ? if3.ack : if2.ack;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 3) ? if3.busy : if2.busy;
  endfunction

  function automatic logic [31:0] get_rdata(input int which);
    return (which == 3) ? if3.rdata : if2.rdata;
  endfunction

  // One request; lat = edges from capture to the edge that raised ack, -1 on timeout.
  task automatic xact(input int which, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input bit scramble, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = 32'h0;
    @(negedge clk);
    set_bus(which, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    if (scramble) set_bus(which, 1'b0, ~w, 8'h11, 32'h12345678);
    else          set_bus(which, 1'b0, w, a, d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_ack(which)) begin
        lat = k;
        rd  = get_rdata(which);
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] rd;
    xact(2, 1'b1, 8'h05, 32'h5A5A1234, 1'b0, lat, rd);
    model_store(2, 8'h05, 32'h5A5A1234);
    xact(2, 1'b0, 8'h05, 32'h0, 1'b0, lat, rd);
    checks++;
    if (rd !== 32'h5A5A1234) begin
      errors++; $display("FAIL reset_preload: rdata=%h expected=%h", rd, 32'h5A5A1234);
    end
    @(negedge clk);
    set_bus(2, 1'b1, 1'b0, 8'h05, 32'h0);
    set_bus(3, 1'b1, 1'b0, 8'h05, 32'h0);
    @(posedge clk);
    #2;
    checks++;
    if (if2.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy_before: busy=%b expected=1", if2.busy);
    end
    rst_f = 1'b0;
    #1;
    checks++;
    if (if2.rdata !== 32'h0 || if2.ack !== 1'b0 || if2.busy !== 1'b0) begin
      errors++; $display("FAIL reset_async_w2: rdata=%h ack=%b busy=%b expected 0/0/0", if2.rdata, if2.ack, if2.busy);
    end
    checks++;
    if (if3.rdata !== 32'h0 || if3.ack !== 1'b0 || if3.busy !== 1'b0) begin
      errors++; $display("FAIL reset_async_w3: rdata=%h ack=%b busy=%b expected 0/0/0", if3.rdata, if3.ack, if3.busy);
    end
    @(negedge clk);
    @(negedge clk);
    set_bus(2, 1'b0, 1'b0, 8'h00, 32'h0);
    set_bus(3, 1'b0, 1'b0, 8'h00, 32'h0);
    rst_f = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if2.ack !== 1'b0 || if2.busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle: ack=%b busy=%b expected 0/0", if2.ack, if2.busy);
      end
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    xact(2, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, lat, rd);
    model_store(2, 8'h10, 32'hDEADBEEF);
    checks++;
    if (lat != exp_lat(2, 1'b1)) begin
      errors++; $display("FAIL store_lat: latency=%0d expected=%0d", lat, exp_lat(2, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (if2.ack !== 1'b0 || if2.busy !== 1'b0) begin
      errors++; $display("FAIL store_ack_width: ack=%b busy=%b expected 0/0", if2.ack, if2.busy);
    end
    xact(2, 1'b0, 8'h10, 32'h0, 1'b0, lat, rd);
    checks++;
    if (lat != exp_lat(2, 1'b0) || rd !== ref_mem[0][8'h10]) begin
      errors++; $display("FAIL load_data: latency=%0d rdata=%h expected %0d/%h", lat, rd, exp_lat(2, 1'b0), ref_mem[0][8'h10]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (if2.rdata !== 32'hDEADBEEF || if2.ack !== 1'b0) begin
        errors++; $display("FAIL load_hold: rdata=%h ack=%b expected DEADBEEF/0", if2.rdata, if2.ack);
      end
    end
    xact(2, 1'b1, 8'h12, 32'h01020304, 1'b0, lat, rd);
    model_store(2, 8'h12, 32'h01020304);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_keeps_rdata: rdata=%h expected DEADBEEF", rd);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    logic [31:0] rd;
    xact(2, 1'b1, 8'h11, 32'h0BADF00D, 1'b0, lat, rd);
    model_store(2, 8'h11, 32'h0BADF00D);
    xact(2, 1'b1, 8'h10, 32'h11111111, 1'b1, lat, rd);
    model_store(2, 8'h10, 32'h11111111);
    xact(2, 1'b0, 8'h10, 32'h0, 1'b0, lat, rd);
    checks++;
    if (rd !== ref_mem[0][8'h10]) begin
      errors++; $display("FAIL busy_ignore_target: rdata=%h expected=%h", rd, ref_mem[0][8'h10]);
    end
    xact(2, 1'b0, 8'h11, 32'h0, 1'b0, lat, rd);
    checks++;
    if (rd !== ref_mem[0][8'h11]) begin
      errors++; $display("FAIL busy_ignore_other: rdata=%h expected=%h", rd, ref_mem[0][8'h11]);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    logic [31:0] rd2 = 32'h0;
    @(negedge clk);
    set_bus(2, 1'b1, 1'b1, 8'h30, 32'h3C3CA5A5);
    model_store(2, 8'h30, 32'h3C3CA5A5);
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if2.ack) begin
        if (first < 0) begin
          first = c;
          set_bus(2, 1'b1, 1'b0, 8'h30, 32'h0);
        end else begin
          second = c;
          rd2 = if2.rdata;
          set_bus(2, 1'b0, 1'b0, 8'h00, 32'h0);
          break;
        end
      end
      @(posedge clk);
    end
    checks++;
    if (first != exp_lat(2, 1'b1)) begin
      errors++; $display("FAIL b2b_first: latency=%0d expected=%0d", first, exp_lat(2, 1'b1));
    end
    checks++;
    if (second < 0 || second - first != 4) begin
      errors++; $display("FAIL b2b_spacing: gap=%0d expected=4", second - first);
    end
    checks++;
    if (rd2 !== ref_mem[0][8'h30]) begin
      errors++; $display("FAIL b2b_data: rdata=%h expected=%h", rd2, ref_mem[0][8'h30]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    xact(2, 1'b1, 8'h20, 32'h00000000, 1'b0, lat, rd);
    model_store(2, 8'h20, 32'h00000000);
    @(negedge clk);
    set_bus(2, 1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    set_bus(2, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge clk);
    #2;
    rst_f = 1'b0;
    // A posted store has already been written at its capture edge.
    if (POSTED) model_store(2, 8'h20, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    xact(2, 1'b0, 8'h20, 32'h0, 1'b0, lat, rd);
    checks++;
    if (lat != exp_lat(2, 1'b0) || rd !== ref_mem[0][8'h20]) begin
      errors++; $display("FAIL reset_mid_abort: latency=%0d rdata=%h expected %0d/%h", lat, rd, exp_lat(2, 1'b0), ref_mem[0][8'h20]);
    end
  endtask

  task automatic test_wait3();
    int lat;
    logic [31:0] rd;
    xact(3, 1'b1, 8'h50, 32'h7E57DA7A, 1'b0, lat, rd);
    model_store(3, 8'h50, 32'h7E57DA7A);
    checks++;
    if (lat != exp_lat(3, 1'b1)) begin
      errors++; $display("FAIL w3_store_lat: latency=%0d expected=%0d", lat, exp_lat(3, 1'b1));
    end
    xact(3, 1'b0, 8'h50, 32'h0, 1'b0, lat, rd);
    checks++;
    if (lat != 3 || rd !== ref_mem[1][8'h50]) begin
      errors++; $display("FAIL w3_load: latency=%0d rdata=%h expected 3/%h", lat, rd, ref_mem[1][8'h50]);
    end
  endtask

  task automatic test_random();
    int lat;
    int which;
    logic w;
    logic [7:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    for (int n = 0; n < 60; n++) begin
      which = ($urandom_range(0, 1) == 0) ? 2 : 3;
      w     = 1'($urandom_range(0, 1));
      a     = 8'h40 + 8'($urandom_range(0, 7));
      d     = $urandom;
      xact(which, w, a, d, 1'b0, lat, rd);
      checks++;
      if (lat != exp_lat(which, w)) begin
        errors++; $display("FAIL rand_lat: dut=W%0d we=%b latency=%0d expected=%0d", which, w, lat, exp_lat(which, w));
      end
      if (w) begin
        model_store(which, a, d);
      end else if (ref_known[which - 2][a]) begin
        checks++;
        if (rd !== ref_mem[which - 2][a]) begin
          errors++; $display("FAIL rand_load: dut=W%0d addr=%h rdata=%h expected=%h", which, a, rd, ref_mem[which - 2][a]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_known[0][i] = 1'b0;
      ref_known[1][i] = 1'b0;
      ref_mem[0][i]   = 32'h0;
      ref_mem[1][i]   = 32'h0;
    end
    set_bus(2, 1'b0, 1'b0, 8'h00, 32'h0);
    set_bus(3, 1'b0, 1'b0, 8'h00, 32'h0);
    rst_f = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    test_reset();
    test_store_load();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_wait3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
